jtag_debug_sys_cmd_ctrl: RTL



---
 rtl/jtag_debug_sys_cmd_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_debug_sys_cmd_ctrl.sv
// Runs PIO command bytes (halt/resume/step/core reset) against the core debug pins, returns a status byte.
// One accepted command at a time; a new toggle waits in cmd until the FSM is back in IDLE.
module jtag_debug_sys_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RST_CYCLES     = 16,
    parameter bit          HALT_ON_RESET  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cmd,
    input  logic       core_halted,
    input  logic       instr_retire,
    output logic       halt_req,
    output logic       core_rst_n,
    output logic [7:0] status
);
    typedef enum logic [2:0] {IDLE, EXEC, HALT_WAIT, STEP_RUN, RST_HOLD} state_t;

    localparam logic [2:0]  OP_NOP    = 3'd0;
    localparam logic [2:0]  OP_HALT   = 3'd1;
    localparam logic [2:0]  OP_RESUME = 3'd2;
    localparam logic [2:0]  OP_STEP   = 3'd3;
    localparam logic [2:0]  OP_RESET  = 3'd4;
    localparam logic [2:0]  OP_CLR    = 3'd5;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RST_LOAD  = 8'(RST_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  op, op_nxt;
    logic [3:0]  arg, arg_nxt;
    logic [3:0]  step_cnt, step_cnt_nxt;
    logic [15:0] tcnt, tcnt_nxt;
    logic [7:0]  rcnt, rcnt_nxt;
    logic        acc_tog, acc_tog_nxt;
    logic        ack_tog, ack_tog_nxt;
    logic        halt_nxt, rst_n_nxt;
    logic        err_op, err_op_nxt;
    logic        err_nh, err_nh_nxt;
    logic        err_tmo, err_tmo_nxt;
    logic        busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op         <= 3'd0;
            arg        <= 4'd0;
            step_cnt   <= 4'd0;
            tcnt       <= 16'd0;
            rcnt       <= 8'd0;
            acc_tog    <= 1'b0;
            ack_tog    <= 1'b0;
            halt_req   <= HALT_ON_RESET;
            core_rst_n <= 1'b1;
            err_op     <= 1'b0;
            err_nh     <= 1'b0;
            err_tmo    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            op         <= op_nxt;
            arg        <= arg_nxt;
            step_cnt   <= step_cnt_nxt;
            tcnt       <= tcnt_nxt;
            rcnt       <= rcnt_nxt;
            acc_tog    <= acc_tog_nxt;
            ack_tog    <= ack_tog_nxt;
            halt_req   <= halt_nxt;
            core_rst_n <= rst_n_nxt;
            err_op     <= err_op_nxt;
            err_nh     <= err_nh_nxt;
            err_tmo    <= err_tmo_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        op_nxt       = op;
        arg_nxt      = arg;
        step_cnt_nxt = step_cnt;
        tcnt_nxt     = tcnt;
        rcnt_nxt     = rcnt;
        acc_tog_nxt  = acc_tog;
        ack_tog_nxt  = ack_tog;
        halt_nxt     = halt_req;
        rst_n_nxt    = core_rst_n;
        err_op_nxt   = err_op;
        err_nh_nxt   = err_nh;
        err_tmo_nxt  = err_tmo;

        unique case (state)
            IDLE: begin
                if (cmd[7] != acc_tog) begin
                    op_nxt      = cmd[6:4];
                    arg_nxt     = cmd[3:0];
                    acc_tog_nxt = cmd[7];
                    state_nxt   = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
                unique case (op)
                    OP_NOP: ;
                    OP_HALT: begin
                        halt_nxt  = 1'b1;
                        tcnt_nxt  = 16'd0;
                        state_nxt = HALT_WAIT;
                    end
                    OP_RESUME: halt_nxt = 1'b0;
                    OP_STEP: begin
                        if (!core_halted) begin
                            err_nh_nxt = 1'b1;
                        end else begin
                            halt_nxt     = 1'b0;
                            step_cnt_nxt = arg;
                            tcnt_nxt     = 16'd0;
                            state_nxt    = STEP_RUN;
                        end
                    end
                    OP_RESET: begin
                        rst_n_nxt = 1'b0;
                        rcnt_nxt  = RST_LOAD;
                        state_nxt = RST_HOLD;
                    end
                    OP_CLR: begin
                        err_op_nxt  = 1'b0;
                        err_nh_nxt  = 1'b0;
                        err_tmo_nxt = 1'b0;
                    end
                    default: err_op_nxt = 1'b1;
                endcase
            end
            HALT_WAIT: begin
                if (core_halted) begin
                    state_nxt = IDLE;
                end else if (tcnt == TMO_LAST) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                end
            end
            STEP_RUN: begin
                // The final retire pulse beats a timeout landing on the same cycle.
                if (instr_retire && step_cnt == 4'd0) begin
                    halt_nxt  = 1'b1;
                    tcnt_nxt  = 16'd0;
                    state_nxt = HALT_WAIT;
                end else if (tcnt == TMO_LAST) begin
                    err_tmo_nxt = 1'b1;
                    halt_nxt    = 1'b1;
                    tcnt_nxt    = 16'd0;
                    state_nxt   = HALT_WAIT;
                end else begin
                    tcnt_nxt = tcnt + 16'd1;
                    if (instr_retire) begin
                        step_cnt_nxt = step_cnt - 4'd1;
                    end
                end
            end
            RST_HOLD: begin
                if (rcnt == 8'd0) begin
                    rst_n_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    rcnt_nxt = rcnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Every path back to IDLE acknowledges the command, errors included.
        if (state != IDLE && state_nxt == IDLE) begin
            ack_tog_nxt = acc_tog;
        end
    end

    assign status = {ack_tog, 1'b0, halt_req, err_tmo, err_nh, err_op, busy, core_halted};

endmodule
